// File: rtl/vdp_port.sv
// vdp_port: Z80-side VDP port controller.
//
// It decodes the two-byte control latch, data port accesses and status
// reads. It drives a single-outstanding VRAM req/ack channel, backed by a
// one-deep command slot, plus CRAM write strobes, the register file, the
// status flags and the interrupt line.
//
// VRAM channel handshake: vram_req rises with vram_we/vram_addr/vram_wdata
// and holds them stable until a cycle in which vram_ack is high. That cycle
// completes the access; vram_rdata is taken in the same cycle for reads, and
// vram_req drops on the following cycle. An ack while vram_req is low means
// nothing.
module vdp_port #(
  parameter int ADDR_BITS = 14,
  parameter int NUM_REGS  = 11,
  parameter int CRAM_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_ctrl,
  input  logic                  wr_data,
  input  logic                  rd_ctrl,
  input  logic                  rd_data,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [ADDR_BITS-1:0]  vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic                  vram_ack,
  input  logic [7:0]            vram_rdata,
  output logic                  cram_we,
  output logic [CRAM_BITS-1:0]  cram_addr,
  output logic [7:0]            cram_wdata,
  output logic [8*NUM_REGS-1:0] regs,
  input  logic                  frame_set,
  input  logic                  line_set,
  input  logic                  ovf_set,
  input  logic                  coll_set,
  input  logic [4:0]            sprite5,
  output logic                  n_int,
  output logic                  overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_SLOT} state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 pending;
  logic [7:0]           lo;
  logic [1:0]           code;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           read_buf;
  logic                 frame_f;
  logic                 line_f;
  logic                 ovf_f;
  logic                 coll_f;
  logic                 slot_full;
  logic                 slot_we;
  logic [7:0]           slot_wdata;
  logic [7:0]           reg_file [NUM_REGS];

  // Command decode
  logic                 ctrl_second;
  logic [1:0]           new_code;
  logic [ADDR_BITS-1:0] new_addr;
  logic                 data_cram;
  logic                 enq_write;
  logic                 enq_read;
  logic                 enq;
  logic [ADDR_BITS-1:0] enq_addr;
  logic                 ack_take;
  logic                 busy;
  logic                 slot_free;
  logic                 to_slot;
  logic                 drop;
  logic                 reload;
  logic [1:0]           addr_inc;

  assign ctrl_second = wr_ctrl & pending;
  assign new_code    = cpu_din[7:6];
  assign new_addr    = ADDR_BITS'({cpu_din[5:0], lo});
  assign data_cram   = wr_data & (code == 2'd3);
  assign enq_write   = wr_data & (code != 2'd3);
  assign enq_read    = rd_data | (ctrl_second & (new_code == 2'd0));
  assign enq         = enq_write | enq_read;
  // A code-0 control write targets the address it is loading right now.
  assign enq_addr    = ctrl_second ? new_addr : addr;
  assign ack_take    = (state_q == ST_ACCESS) & vram_ack;
  assign busy        = (state_q != ST_IDLE);
  // In SLOT the slot empties this cycle, so a new command can take its place.
  assign slot_free   = ~slot_full | (state_q == ST_SLOT);
  assign to_slot     = enq & busy & slot_free;
  assign drop        = enq & busy & ~slot_free;
  // A register write leaves the address alone while an access is in flight.
  assign reload      = ctrl_second & ~(busy & (new_code == 2'd2));
  assign addr_inc    = {1'b0, ack_take} + {1'b0, data_cram};

  assign n_int = ~((frame_f & reg_file[1][5]) | (line_f & reg_file[0][4]));

  // Flatten the register file onto the regs bus
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[8*g +: 8] = reg_file[g];
  end

  // Access FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Access FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enq) state_d = ST_ACCESS;
      ST_ACCESS: if (ack_take) state_d = (slot_full | to_slot) ? ST_SLOT : ST_IDLE;
      ST_SLOT:   state_d = ST_ACCESS;
      default:   state_d = ST_IDLE;
    endcase
  end

  // VRAM request channel and the one-deep command slot
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_req   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
      slot_full  <= 1'b0;
      slot_we    <= 1'b0;
      slot_wdata <= 8'h00;
      overrun    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enq) begin
            vram_req   <= 1'b1;
            vram_we    <= enq_write;
            vram_addr  <= enq_addr;
            vram_wdata <= cpu_din;
          end
        end
        ST_ACCESS: begin
          if (ack_take) vram_req <= 1'b0;
        end
        ST_SLOT: begin
          vram_req   <= 1'b1;
          vram_we    <= slot_we;
          vram_addr  <= addr;
          vram_wdata <= slot_wdata;
        end
        default: vram_req <= 1'b0;
      endcase
      if (state_q == ST_SLOT) slot_full <= 1'b0;
      if (to_slot) begin
        slot_full  <= 1'b1;
        slot_we    <= enq_write;
        slot_wdata <= cpu_din;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  // Control latch, address pointer, read buffer and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      lo       <= 8'h00;
      code     <= 2'd0;
      addr     <= '0;
      read_buf <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= 8'h00;
    end else begin
      if (wr_ctrl)                          pending <= ~pending;
      else if (rd_ctrl | rd_data | wr_data) pending <= 1'b0;
      if (wr_ctrl & ~pending) lo <= cpu_din;
      if (ctrl_second) code <= new_code;
      if (reload) addr <= new_addr;
      else        addr <= addr + ADDR_BITS'(addr_inc);
      if (ack_take & ~vram_we) read_buf <= vram_rdata;
      else if (enq_write)      read_buf <= cpu_din;
      if (ctrl_second & (new_code == 2'd2)) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (cpu_din[5:0] == 6'(i)) reg_file[i] <= lo;
      end
    end
  end

  // CPU read data, CRAM strobe and status flags (a set beats a clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_dout   <= 8'h00;
      cram_we    <= 1'b0;
      cram_addr  <= '0;
      cram_wdata <= 8'h00;
      frame_f    <= 1'b0;
      line_f     <= 1'b0;
      ovf_f      <= 1'b0;
      coll_f     <= 1'b0;
    end else begin
      if (rd_data)      cpu_dout <= read_buf;
      else if (rd_ctrl) cpu_dout <= {frame_f, ovf_f, coll_f, ovf_f ? sprite5 : 5'h1F};
      cram_we <= data_cram;
      if (data_cram) begin
        cram_addr  <= addr[CRAM_BITS-1:0];
        cram_wdata <= cpu_din;
      end
      frame_f <= frame_set | (frame_f & ~rd_ctrl);
      line_f  <= line_set  | (line_f  & ~rd_ctrl);
      ovf_f   <= ovf_set   | (ovf_f   & ~rd_ctrl);
      coll_f  <= coll_set  | (coll_f  & ~rd_ctrl);
    end
  end

endmodule
